// File: rtl/tdc_capture_framer.sv
// Multi-channel start/stop interval timer that packs each captured interval into a byte frame for a UART.
// Optional build macro TDC_FRAME_CHECKSUM_EN appends an XOR checksum byte to every frame.
module tdc_capture_framer #(
  parameter int N_CH    = 4,
  parameter int COUNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] start,
  input  logic [N_CH-1:0] stop,
  output logic [7:0]      axi_data,
  output logic            axi_valid,
  input  logic            axi_ready,
  output logic [N_CH-1:0] busy
);

  localparam int NB = COUNT_W / 8;
`ifdef TDC_FRAME_CHECKSUM_EN
  localparam int LAST_IDX = NB + 1;
`else
  localparam int LAST_IDX = NB;
`endif
  localparam int IDX_W = $clog2(LAST_IDX + 1);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COUNT = 2'd1, ST_PEND = 2'd2} state_t;

  logic [N_CH-1:0]         r_start_s1, r_start_s2, r_start_d;
  logic [N_CH-1:0]         r_stop_s1, r_stop_s2, r_stop_d;
  logic [1:0]              r_warm;
  logic                    w_armed;
  logic [N_CH-1:0]         w_start_det, w_stop_det, w_pend, w_ovf, w_release;
  logic [N_CH*COUNT_W-1:0] w_cnt_flat;

  // Edges stay masked until every synchronizer stage holds a post-reset sample,
  // so a level held high across reset release is not mistaken for an edge.
  assign w_armed     = (r_warm == 2'd3);
  assign w_start_det = r_start_s2 & ~r_start_d & {N_CH{w_armed}};
  assign w_stop_det  = r_stop_s2 & ~r_stop_d & {N_CH{w_armed}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_s1 <= '0;
      r_start_s2 <= '0;
      r_start_d  <= '0;
      r_stop_s1  <= '0;
      r_stop_s2  <= '0;
      r_stop_d   <= '0;
      r_warm     <= 2'd0;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
      r_stop_s1  <= stop;
      r_stop_s2  <= r_stop_s1;
      r_stop_d   <= r_stop_s2;
      if (!w_armed) r_warm <= r_warm + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t             r_state, w_state_next;
      logic [COUNT_W-1:0] r_cnt;
      logic               r_ovf;

      always_comb begin
        w_state_next = r_state;
        case (r_state)
          ST_IDLE:  if (w_start_det[gi]) w_state_next = ST_COUNT;
          ST_COUNT: if (w_stop_det[gi])  w_state_next = ST_PEND;
          ST_PEND:  if (w_release[gi])   w_state_next = ST_IDLE;
          default:  w_state_next = ST_IDLE;
        endcase
      end

      // The counter also advances in the stop cycle, so the held value equals
      // the distance from start-detect to stop-detect.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
        end else begin
          r_state <= w_state_next;
          if (r_state == ST_IDLE && w_start_det[gi]) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end else if (r_state == ST_COUNT) begin
            if (r_cnt == '1) r_ovf <= 1'b1;
            else             r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign busy[gi]                           = (r_state != ST_IDLE);
      assign w_pend[gi]                         = (r_state == ST_PEND);
      assign w_ovf[gi]                          = r_ovf;
      assign w_cnt_flat[gi*COUNT_W +: COUNT_W]  = r_cnt;
    end
  endgenerate

  logic               r_valid;
  logic [7:0]         r_data;
  logic [CH_W-1:0]    r_sel, r_rr_ptr;
  logic [IDX_W-1:0]   r_idx;
`ifdef TDC_FRAME_CHECKSUM_EN
  logic [7:0]         r_csum;
`endif
  logic               w_found, w_found_hi, w_found_lo;
  logic [CH_W-1:0]    w_pick, w_pick_hi, w_pick_lo;
  logic               w_pick_ovf;
  logic [COUNT_W-1:0] w_sel_cnt;
  logic [IDX_W-1:0]   w_next_idx;
  logic [7:0]         w_next_byte;
  logic               w_accept, w_last;

  // Round robin: lowest pending channel at or above the pointer, else lowest overall.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    for (int m = N_CH - 1; m >= 0; m--) begin
      if (w_pend[m]) begin
        w_found_lo = 1'b1;
        w_pick_lo  = CH_W'(m);
        if (CH_W'(m) >= r_rr_ptr) begin
          w_found_hi = 1'b1;
          w_pick_hi  = CH_W'(m);
        end
      end
    end
    w_found = w_found_lo;
    w_pick  = w_found_hi ? w_pick_hi : w_pick_lo;
  end

  always_comb begin
    w_pick_ovf = 1'b0;
    w_sel_cnt  = '0;
    w_release  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_pick == CH_W'(k)) w_pick_ovf = w_ovf[k];
      if (r_sel == CH_W'(k)) begin
        w_sel_cnt    = w_cnt_flat[k*COUNT_W +: COUNT_W];
        w_release[k] = w_accept & w_last;
      end
    end
  end

  assign w_accept   = r_valid & axi_ready;
  assign w_last     = (r_idx == IDX_W'(LAST_IDX));
  assign w_next_idx = r_idx + 1'b1;

  always_comb begin
    w_next_byte = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (w_next_idx == IDX_W'(b + 1)) w_next_byte = w_sel_cnt[(NB-1-b)*8 +: 8];
    end
`ifdef TDC_FRAME_CHECKSUM_EN
    if (w_next_idx == IDX_W'(NB + 1)) w_next_byte = r_csum ^ r_data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= 8'h00;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_idx    <= '0;
`ifdef TDC_FRAME_CHECKSUM_EN
      r_csum   <= 8'h00;
`endif
    end else if (!r_valid) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_sel   <= w_pick;
        r_idx   <= '0;
        r_data  <= {1'b1, w_pick_ovf, 6'(w_pick)};
`ifdef TDC_FRAME_CHECKSUM_EN
        r_csum  <= 8'h00;
`endif
      end
    end else if (w_accept) begin
      if (w_last) begin
        r_valid  <= 1'b0;
        r_data   <= 8'h00;
        r_rr_ptr <= (r_sel == CH_W'(N_CH - 1)) ? '0 : r_sel + 1'b1;
      end else begin
        r_idx  <= w_next_idx;
        r_data <= w_next_byte;
`ifdef TDC_FRAME_CHECKSUM_EN
        r_csum <= r_csum ^ r_data;
`endif
      end
    end
  end

  assign axi_valid = r_valid;
  assign axi_data  = r_data;

endmodule

// File: tb/tb_tdc_capture_framer.sv
// Directed bench for tdc_capture_framer: a frame model built from the driven edge times feeds a per-cycle monitor.
module tb_tdc_capture_framer;
  localparam int N_CH    = 4;
  localparam int COUNT_W = 16;
  localparam int NB      = COUNT_W / 8;
`ifdef TDC_FRAME_CHECKSUM_EN
  localparam int FLEN = NB + 2;
`else
  localparam int FLEN = NB + 1;
`endif
  localparam int CMAX = (1 << COUNT_W) - 1;

  logic            clk, rst, axi_valid, axi_ready;
  logic [N_CH-1:0] start, stop, busy;
  logic [7:0]      axi_data;

  tdc_capture_framer #(.N_CH(N_CH), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .axi_data(axi_data), .axi_valid(axi_valid), .axi_ready(axi_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  logic [7:0] exp_q [N_CH][$];
  int         log_ch[$], log_first[$], log_last[$];
  logic [7:0] log_bytes[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Expected frame from the interval length the bench itself drove.
  function automatic void push_frame(input int ch, input int cycles);
    int         res;
    logic       ovf;
    logic [7:0] b;
    ovf = (cycles > CMAX);
    res = ovf ? CMAX : cycles;
    b = {1'b1, ovf, 6'(ch)};
    exp_q[ch].push_back(b);
    for (int k = 0; k < NB; k++) begin
      b = 8'(res >> (8 * (NB - 1 - k)));
      exp_q[ch].push_back(b);
    end
`ifdef TDC_FRAME_CHECKSUM_EN
    begin : g_cs
      logic [7:0] cs;
      cs = 8'h00;
      for (int k = 0; k < NB + 1; k++) cs ^= exp_q[ch][exp_q[ch].size() - 1 - k];
      exp_q[ch].push_back(cs);
    end
`endif
  endfunction

  int         m_idx = 0;
  int         m_ch  = 0;
  int         m_first = 0;
  logic       m_prev_hold = 1'b0;
  logic [7:0] m_prev_data = 8'h00;
  logic [7:0] m_exp [FLEN];
  logic [7:0] m_got [FLEN];

  always @(negedge clk) begin
    if (rst) begin
      m_idx       = 0;
      m_prev_hold = 1'b0;
    end else begin
      if (m_prev_hold) begin
        check("hold_valid", axi_valid, 1'b1);
        check("hold_data", axi_data, m_prev_data);
      end
      m_prev_hold = axi_valid && !axi_ready;
      m_prev_data = axi_data;
      if (axi_valid && axi_ready) begin
        if (m_idx == 0) begin
          m_ch    = int'(axi_data[5:0]);
          m_first = cyc;
          check("frame_expected", (m_ch < N_CH) && (exp_q[m_ch].size() >= FLEN), 1'b1);
          for (int k = 0; k < FLEN; k++)
            m_exp[k] = ((m_ch < N_CH) && (exp_q[m_ch].size() > 0)) ? exp_q[m_ch].pop_front() : 8'h00;
        end
        check($sformatf("byte%0d_ch%0d", m_idx, m_ch), axi_data, m_exp[m_idx]);
        m_got[m_idx] = axi_data;
        m_idx++;
        if (m_idx == FLEN) begin
          log_ch.push_back(m_ch);
          log_first.push_back(m_first);
          log_last.push_back(cyc);
          for (int k = 0; k < FLEN; k++) log_bytes.push_back(m_got[k]);
          $display("frame ch=%0d cycles %0d..%0d hdr=%02h r1=%02h r0=%02h",
                   m_ch, m_first, cyc, m_got[0], m_got[1], m_got[2]);
          m_idx = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (log_ch.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_timeout", log_ch.size() >= n, 1'b1);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!axi_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("valid_rise", axi_valid, 1'b1);
  endtask

  task automatic check_lit(input int f, input string name,
                           input logic [7:0] h, input logic [7:0] r1, input logic [7:0] r0);
    check({name, "_hdr"}, log_bytes[f*FLEN],     h);
    check({name, "_r1"},  log_bytes[f*FLEN + 1], r1);
    check({name, "_r0"},  log_bytes[f*FLEN + 2], r0);
`ifdef TDC_FRAME_CHECKSUM_EN
    check({name, "_cs"},  log_bytes[f*FLEN + 3], h ^ r1 ^ r0);
`endif
  endtask

  initial begin
    int   n0;
    logic seen;
    logic [7:0] hdr;
    rst = 1'b0; start = '0; stop = '0; axi_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_valid", axi_valid, 1'b0);
    check("rst_data", axi_data, 8'h00);
    check("rst_busy", busy, '0);
    tick(3);
    rst = 1'b0;
    tick(5);

    // Two channels finishing together: ch0 served first, then ch2 after at most one idle cycle.
    n0 = log_ch.size();
    start[0] = 1'b1; start[2] = 1'b1;
    tick(5);
    start = '0;
    tick(5);
    stop[0] = 1'b1; stop[2] = 1'b1;
    push_frame(0, 10); push_frame(2, 10);
    tick(5);
    stop = '0;
    wait_frames(n0 + 2, 60);
    check("pair_first_ch", log_ch[n0], 0);
    check("pair_second_ch", log_ch[n0 + 1], 2);
    check("pair_gap_ok", (log_first[n0 + 1] - log_last[n0]) <= 2, 1'b1);
    check_lit(n0, "pair_ch0", 8'h80, 8'h00, 8'h0A);
    check_lit(n0 + 1, "pair_ch2", 8'h82, 8'h00, 8'h0A);
    tick(5);

    // 100-cycle interval on ch1.
    n0 = log_ch.size();
    start[1] = 1'b1;
    tick(5);
    start[1] = 1'b0;
    tick(45);
    check("t100_busy_mid", busy[1], 1'b1);
    tick(50);
    stop[1] = 1'b1;
    push_frame(1, 100);
    tick(5);
    stop[1] = 1'b0;
    wait_frames(n0 + 1, 60);
    check_lit(n0, "t100", 8'h81, 8'h00, 8'h64);
    @(posedge clk); #1;
    check("t100_busy_after", busy[1], 1'b0);
    tick(5);

    // Backpressure on the header; a second start while pending is ignored.
    n0 = log_ch.size();
    axi_ready = 1'b0;
    start[1] = 1'b1;
    tick(3);
    start[1] = 1'b0;
    tick(3);
    stop[1] = 1'b1;
    push_frame(1, 6);
    wait_valid(30);
    hdr = axi_data;
    check("bp_hdr", hdr, 8'h81);
    tick(1);
    start[1] = 1'b1;
    tick(20);
    check("bp_valid_held", axi_valid, 1'b1);
    check("bp_data_held", axi_data, hdr);
    check("bp_busy", busy[1], 1'b1);
    axi_ready = 1'b1;
    wait_frames(n0 + 1, 30);
    check_lit(n0, "bp", 8'h81, 8'h00, 8'h06);
    tick(5);
    check("bp_no_retrigger", busy[1], 1'b0);
    start[1] = 1'b0; stop[1] = 1'b0;
    tick(5);

    // Stop alone does nothing; simultaneous start+stop counts until a later stop.
    n0 = log_ch.size();
    stop[3] = 1'b1;
    tick(10);
    check("stoponly_busy", busy[3], 1'b0);
    check("stoponly_noframe", log_ch.size(), n0);
    stop[3] = 1'b0;
    tick(5);
    start[3] = 1'b1; stop[3] = 1'b1;
    tick(6);
    check("simul_busy", busy[3], 1'b1);
    check("simul_noframe", log_ch.size(), n0);
    stop[3] = 1'b0; start[3] = 1'b0;
    tick(4);
    stop[3] = 1'b1;
    push_frame(3, 10);
    tick(5);
    stop[3] = 1'b0;
    wait_frames(n0 + 1, 40);
    check_lit(n0, "simul", 8'h83, 8'h00, 8'h0A);
    tick(5);

    // Reset after the header is accepted abandons the frame; levels held across release are not edges.
    n0 = log_ch.size();
    axi_ready = 1'b0;
    start[2] = 1'b1;
    tick(7);
    stop[2] = 1'b1;
    push_frame(2, 7);
    wait_valid(30);
    tick(1);
    axi_ready = 1'b1;
    tick(1);
    axi_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", axi_valid, 1'b0);
    check("midrst_data", axi_data, 8'h00);
    check("midrst_busy", busy, '0);
    tick(2);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (axi_valid) seen = 1'b1;
    end
    check("midrst_no_resume", seen, 1'b0);
    check("midrst_frames", log_ch.size(), n0);
    check("held_input_busy", busy[2], 1'b0);
    start = '0; stop = '0; axi_ready = 1'b1;
    tick(5);

    // Saturating interval.
    n0 = log_ch.size();
    start[0] = 1'b1;
    tick(5);
    start[0] = 1'b0;
    tick(69995);
    stop[0] = 1'b1;
    push_frame(0, 70000);
    tick(5);
    stop[0] = 1'b0;
    wait_frames(n0 + 1, 40);
    check_lit(n0, "ovf", 8'hC0, 8'hFF, 8'hFF);
    tick(5);

    for (int c = 0; c < N_CH; c++) check($sformatf("exp_left_ch%0d", c), exp_q[c].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
